// File: rtl/fetch_pc_redirect.sv
// Fetch-stage PC generator: sequential fetch, branch redirect with MIPS delay slot, flush override.
// Optional FETCH_ADEL_EN adds misaligned-redirect detection (adel / adel_vaddr outputs).

package fetch_pc_redirect_pkg;
    typedef enum logic [1:0] {J_NOP, J_BR, J_J, J_JR} jmp_stat_t;

    typedef struct packed {
        jmp_stat_t   stat;
        logic [31:0] pc_src;
        logic [31:0] pc_dst;
    } jmp_pack_t;
endpackage

module fetch_pc_redirect
    import fetch_pc_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  jmp_pack_t   jmp,
    input  logic        jmp_delayed,
    input  logic        jmp_valid,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        stall,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_addr_ok,
    output logic [31:0] issued_pc,
    output logic        squash,
    output logic        in_slot
`ifdef FETCH_ADEL_EN
    ,
    output logic        adel,
    output logic [31:0] adel_vaddr
`endif
);

    typedef enum logic {S_RUN, S_SLOT} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_issued;
    logic [31:0] r_target, w_target_nxt;
    logic        w_accept;
    logic        w_jt;
    logic [31:0] w_slot;
    logic        w_squash;

    assign w_jt   = jmp_valid && (jmp.stat != J_NOP);
    assign w_slot = jmp.pc_src + 32'd4;

`ifdef FETCH_ADEL_EN
    logic        r_adel;
    logic [31:0] r_adel_vaddr;
    logic        w_redir;

    assign ireq_valid = !reset && !stall && !flush && !r_adel;
`else
    assign ireq_valid = !reset && !stall && !flush;
`endif

    assign w_accept  = ireq_valid && ireq_addr_ok;
    assign ireq_addr = r_pc;
    assign issued_pc = r_issued;
    assign squash    = w_squash;
    assign in_slot   = (r_state == S_SLOT);

    always_comb begin
        w_pc_nxt     = r_pc;
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_squash     = 1'b0;
        if (flush) begin
            w_pc_nxt    = flush_pc;
            w_state_nxt = S_RUN;
            w_squash    = 1'b1;
        end else if (r_state == S_RUN && w_jt) begin
            if (!jmp_delayed) begin
                w_pc_nxt = jmp.pc_dst;
                w_squash = 1'b1;
            end else if ((r_issued == w_slot) || (w_accept && r_pc == w_slot)) begin
                w_pc_nxt = jmp.pc_dst;
                w_squash = 1'b1;
            end else if (r_issued == jmp.pc_src) begin
                // Slot still ahead of us: park the target and let the slot go out first.
                w_target_nxt = jmp.pc_dst;
                w_state_nxt  = S_SLOT;
                if (w_accept) w_pc_nxt = r_pc + 32'd4;
            end else begin
                w_pc_nxt = jmp.pc_dst;
                w_squash = 1'b1;
            end
        end else if (r_state == S_SLOT) begin
            if (w_accept) begin
                w_pc_nxt    = r_target;
                w_state_nxt = S_RUN;
            end
        end else if (w_accept) begin
            w_pc_nxt = r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_issued <= RESET_PC - 32'd4;
            r_state  <= S_RUN;
            r_target <= 32'd0;
        end else begin
            r_pc     <= w_pc_nxt;
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            if (w_accept) r_issued <= r_pc;
        end
    end

`ifdef FETCH_ADEL_EN
    // Every pc_q redirect either squashes (jump/flush) or is the SLOT exit.
    assign w_redir = w_squash || (r_state == S_SLOT && w_accept);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adel       <= 1'b0;
            r_adel_vaddr <= 32'd0;
        end else if (flush) begin
            r_adel       <= (flush_pc[1:0] != 2'b00);
            r_adel_vaddr <= flush_pc;
        end else if (w_redir && w_pc_nxt[1:0] != 2'b00) begin
            r_adel       <= 1'b1;
            r_adel_vaddr <= w_pc_nxt;
        end
    end

    assign adel       = r_adel;
    assign adel_vaddr = r_adel_vaddr;
`endif

endmodule

// File: tb/tb_fetch_pc_redirect.sv
// Scoreboard bench for fetch_pc_redirect: expected request addresses queued, popped on each accept.
module tb_fetch_pc_redirect;
    import fetch_pc_redirect_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    jmp_pack_t   jmp;
    logic        jmp_delayed, jmp_valid, flush, stall, ireq_addr_ok;
    logic [31:0] flush_pc;
    logic        ireq_valid, squash, in_slot;
    logic [31:0] ireq_addr, issued_pc;
`ifdef FETCH_ADEL_EN
    logic        adel;
    logic [31:0] adel_vaddr;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];

    fetch_pc_redirect dut (
        .clk(clk), .reset(reset), .jmp(jmp), .jmp_delayed(jmp_delayed),
        .jmp_valid(jmp_valid), .flush(flush), .flush_pc(flush_pc), .stall(stall),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr), .ireq_addr_ok(ireq_addr_ok),
        .issued_pc(issued_pc), .squash(squash), .in_slot(in_slot)
`ifdef FETCH_ADEL_EN
        , .adel(adel), .adel_vaddr(adel_vaddr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Request monitor: every accepted request must match the next queued address.
    always @(negedge clk) begin
        if (ireq_valid && ireq_addr_ok) begin
            if (exp_q.size() == 0) chk("unexp_req", exp_q.size(), 1);
            else chk("req_addr", ireq_addr, exp_q.pop_front());
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        jmp          = '0;
        jmp_valid    = 1'b0;
        jmp_delayed  = 1'b0;
        flush        = 1'b0;
        flush_pc     = 32'd0;
        stall        = 1'b0;
        ireq_addr_ok = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_ireq_valid", ireq_valid, 0);
        chk("rst_squash", squash, 0);
        nxt();
        reset = 1'b0;
        chk("rst_pc", ireq_addr, 32'hBFC0_0000);
        chk("rst_issued", issued_pc, 32'hBFBF_FFFC);
        chk("rst_in_slot", in_slot, 0);
    endtask

    task automatic br(input jmp_stat_t st, input logic [31:0] src, input logic [31:0] dst,
                      input logic dly);
        jmp_valid   = 1'b1;
        jmp         = '{stat: st, pc_src: src, pc_dst: dst};
        jmp_delayed = dly;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        nxt();

        // Sequential fetch after reset
        do_reset();
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        exp_q.push_back(32'hBFC0_0008);
        ireq_addr_ok = 1'b1;
        @(negedge clk);
        chk("seq_valid", ireq_valid, 1);
        nxt();
        repeat (2) nxt();
        ireq_addr_ok = 1'b0;
        chk("seq_issued", issued_pc, 32'hBFC0_0008);

        // Delayed branch resolved before the slot went out: enters SLOT, no squash
        do_reset();
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        exp_q.push_back(32'hBFC0_0100);
        ireq_addr_ok = 1'b1;
        nxt();
        ireq_addr_ok = 1'b0;
        br(J_BR, 32'hBFC0_0000, 32'hBFC0_0100, 1'b1);
        @(negedge clk);
        chk("slot_sq0", squash, 0);
        nxt();
        jmp_valid    = 1'b0;
        ireq_addr_ok = 1'b1;
        @(negedge clk);
        chk("slot_in", in_slot, 1);
        chk("slot_sq1", squash, 0);
        nxt();
        @(negedge clk);
        chk("slot_out", in_slot, 0);
        chk("slot_sq2", squash, 0);
        nxt();
        ireq_addr_ok = 1'b0;

        // Same branch resolved after the slot was issued: immediate redirect
        do_reset();
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        exp_q.push_back(32'hBFC0_0100);
        ireq_addr_ok = 1'b1;
        repeat (2) nxt();
        ireq_addr_ok = 1'b0;
        br(J_BR, 32'hBFC0_0000, 32'hBFC0_0100, 1'b1);
        @(negedge clk);
        chk("late_sq", squash, 1);
        nxt();
        jmp_valid    = 1'b0;
        ireq_addr_ok = 1'b1;
        @(negedge clk);
        chk("late_in_slot", in_slot, 0);
        chk("late_addr", ireq_addr, 32'hBFC0_0100);
        nxt();
        ireq_addr_ok = 1'b0;

        // SLOT held through addr_ok=0 and stall
        do_reset();
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0004);
        exp_q.push_back(32'hBFC0_0100);
        ireq_addr_ok = 1'b1;
        nxt();
        ireq_addr_ok = 1'b0;
        br(J_BR, 32'hBFC0_0000, 32'hBFC0_0100, 1'b1);
        nxt();
        jmp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            stall = (i < 2);
            @(negedge clk);
            chk("hold_addr", ireq_addr, 32'hBFC0_0004);
            chk("hold_slot", in_slot, 1);
            chk("hold_valid", ireq_valid, !stall);
            nxt();
        end
        stall        = 1'b0;
        ireq_addr_ok = 1'b1;
        nxt();
        @(negedge clk);
        chk("hold_exit", in_slot, 0);
        nxt();
        ireq_addr_ok = 1'b0;

        // Flush beats a jump while in SLOT
        do_reset();
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0380);
        ireq_addr_ok = 1'b1;
        nxt();
        ireq_addr_ok = 1'b0;
        br(J_BR, 32'hBFC0_0000, 32'hBFC0_0100, 1'b1);
        nxt();
        br(J_J, 32'hBFC0_0004, 32'hBFC0_0200, 1'b1);
        flush        = 1'b1;
        flush_pc     = 32'hBFC0_0380;
        ireq_addr_ok = 1'b1;
        @(negedge clk);
        chk("fl_sq", squash, 1);
        chk("fl_valid", ireq_valid, 0);
        nxt();
        flush     = 1'b0;
        jmp_valid = 1'b0;
        @(negedge clk);
        chk("fl_in_slot", in_slot, 0);
        chk("fl_addr", ireq_addr, 32'hBFC0_0380);
        nxt();
        ireq_addr_ok = 1'b0;

        // Non-delayed jump with a same-cycle accept
        do_reset();
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'h8000_1000);
        exp_q.push_back(32'h8000_1004);
        ireq_addr_ok = 1'b1;
        br(J_JR, 32'hBFC0_0000, 32'h8000_1000, 1'b0);
        @(negedge clk);
        chk("jr_sq", squash, 1);
        nxt();
        jmp_valid = 1'b0;
        @(negedge clk);
        chk("jr_sq_off", squash, 0);
        nxt();
        nxt();
        ireq_addr_ok = 1'b0;
        chk("jr_issued", issued_pc, 32'h8000_1004);

`ifdef FETCH_ADEL_EN
        // Misaligned redirect blocks fetch until flushed
        do_reset();
        exp_q.push_back(32'hBFC0_0000);
        exp_q.push_back(32'hBFC0_0380);
        ireq_addr_ok = 1'b1;
        br(J_JR, 32'hBFC0_0000, 32'h8000_0002, 1'b0);
        nxt();
        jmp_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("adel", adel, 1);
            chk("adel_vaddr", adel_vaddr, 32'h8000_0002);
            chk("adel_valid", ireq_valid, 0);
            nxt();
        end
        flush    = 1'b1;
        flush_pc = 32'hBFC0_0380;
        nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("adel_clr", adel, 0);
        chk("adel_resume", ireq_valid, 1);
        nxt();
        ireq_addr_ok = 1'b0;
`endif

        chk("q_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_redirect.md
Name: fetch_pc_redirect

Overview:
- Fetch-stage PC generator. It is the consumer of the decode stage's jmp_pack_t / jmp_delayed branch resolution.
- Owns the next-fetch PC and issues word requests to the instruction port.
- Applies MIPS delay-slot semantics: the slot instruction at pc_src+4 is fetched before redirecting to pc_dst.
- Exception/flush redirects override branches.

Parameters:
RESET_PC, 32'hBFC0_0000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
jmp  in  jmp_pack_t  branch resolution from decode (stat, pc_src, pc_dst)
jmp_delayed  in  1  branch has a delay slot
jmp_valid  in  1  jmp/jmp_delayed valid this cycle
flush  in  1  exception/eret redirect
flush_pc  in  32  flush target
stall  in  1  downstream backpressure; no new request
ireq_valid  out  1  instruction request valid
ireq_addr  out  32  request address (= pc_q)
ireq_addr_ok  in  1  request accepted this cycle
issued_pc  out  32  address of last accepted request
squash  out  1  one-cycle pulse: discard in-flight responses except the delay slot
in_slot  out  1  state == SLOT

Behaviour:
- Reset (synchronous, active-high):
  - pc_q=RESET_PC, issued_pc=RESET_PC-4, state=RUN, target_q=0.
  - squash=0; ireq_valid=0 during the reset cycle.
- Request handshake:
  - ireq_valid = !reset && !stall && !flush.
  - accept = ireq_valid && ireq_addr_ok.
  - On accept: issued_pc<=pc_q; pc_q<=next (below).
  - ireq_addr is stable while ireq_valid && !ireq_addr_ok.
- Taken jump: jt = jmp_valid && jmp.stat != J_NOP. slot = jmp.pc_src+4 (32-bit wrap).
- Priority, evaluated each cycle:
  1. flush: pc_q<=flush_pc, state<=RUN, squash=1. Any jump this cycle is dropped.
  2. state RUN, jt, jmp_delayed=0: pc_q<=jmp.pc_dst, squash=1.
  3. state RUN, jt, jmp_delayed=1:
     - slot already issued (issued_pc==slot), or slot accepted this cycle (accept && pc_q==slot): pc_q<=pc_dst, squash=1, stay RUN.
     - slot not yet issued (issued_pc==pc_src): target_q<=pc_dst, state<=SLOT. pc_q continues as sequential (== slot); accept updates it.
     - any other issued_pc: treated as slot issued (redirect, squash=1).
  4. state SLOT:
     - On accept: pc_q<=target_q, state<=RUN, squash=0. The slot is the last good fetch; later requests cannot exist.
     - jt while in SLOT is ignored (branch in delay slot is undefined).
  5. Otherwise, on accept: pc_q<=pc_q+4.
- stall:
  - Blocks requests only. Jumps and flush are still captured in the stall cycle.
  - SLOT persists across stall.
- squash is combinational from the current-cycle decision, high for exactly that cycle.
- in_slot is registered.
- Mid-operation reset: SLOT state and target are discarded; restart at RESET_PC.

Optional Feature:
FETCH_ADEL_EN:
- Defined:
  - Adds outputs adel (1) and adel_vaddr (32).
  - On any redirect (jump, target_q, flush) to an address with [1:0]!=0: the redirect happens, but ireq_valid is held low.
  - adel=1 and adel_vaddr=that address are held until flush.
- Undefined: ports are absent and targets are used unmodified.

Test Plan:
- Reset then no stall, addr_ok=1 → ireq_addr BFC00000, BFC00004, BFC00008 on consecutive cycles; first-cycle ireq_valid=0.
- BEQ at pc_src=BFC00000 resolved when issued_pc=BFC00000, pc_dst=BFC00100, delayed=1 → in_slot=1; next accepted request is BFC00004, then BFC00100; squash never 1.
- Same branch resolved when issued_pc=BFC00004 → squash=1 that cycle; next request BFC00100; in_slot stays 0.
- Branch enters SLOT with addr_ok=0 for 3 cycles and stall=1 for 2 → ireq_addr held at slot address; after accept, request is pc_dst.
- flush=1 (flush_pc=BFC00380) in the same cycle as a taken jump in SLOT → next request BFC00380, in_slot=0, squash=1.
- FETCH_ADEL_EN: JR to 80000002 → adel=1, adel_vaddr=80000002, ireq_valid=0 until flush clears it.
